fpu_result_queue: RTL

FPU_RESULT_QUEUE -- requirements
Module: fpu_result_queue

---
 rtl/fpu_result_queue.sv | 98 +++++++++
 1 files changed

// File: rtl/fpu_result_queue.sv
// FPU result queue: circular FIFO of {result, status, tag} between the FPU and its consumer.
// Also keeps the sticky OR of the status of every retired result (fflags).
module fpu_result_queue #(
    parameter int DWIDTH    = 16,
    parameter int TAG_WIDTH = 1,
    parameter int DEPTH     = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic [DWIDTH-1:0]          result_i,
    input  logic [4:0]                 status_i,
    input  logic [TAG_WIDTH-1:0]       tag_i,
    input  logic                       in_valid_i,
    output logic                       in_ready_o,
    input  logic                       flush_i,
    output logic [DWIDTH-1:0]          result_o,
    output logic [4:0]                 status_o,
    output logic [TAG_WIDTH-1:0]       tag_o,
    output logic                       out_valid_o,
    input  logic                       out_ready_i,
    output logic [4:0]                 fflags_o,
    input  logic                       fflags_clr_i,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_check
        $error("fpu_result_queue: DEPTH must be a power of two >= 2");
    end

    typedef struct packed {
        logic [DWIDTH-1:0]    result;
        logic [4:0]           status;
        logic [TAG_WIDTH-1:0] tag;
    } entry_t;

    entry_t          mem [DEPTH];
    entry_t          head;
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   wr_ptr;
    logic [CW-1:0]   count;
    logic [4:0]      fflags;
    logic            push;
    logic            pop;

    // Ready depends only on registered occupancy, so a full queue stays
    // not-ready even in a cycle where the head is being retired.
    assign in_ready_o  = (count < CW'(DEPTH));
    assign out_valid_o = (count != '0);

    assign push = in_valid_i && in_ready_o;
    assign pop  = out_valid_o && out_ready_i;

    assign head     = mem[rd_ptr];
    assign result_o = head.result;
    assign status_o = head.status;
    assign tag_o    = head.tag;
    assign fflags_o = fflags;
    assign count_o  = count;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush_i) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= '{result: result_i, status: status_i, tag: tag_i};
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

    // A flushed pop is not a retirement, so its status is not merged.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fflags <= '0;
        end else if (fflags_clr_i) begin
            fflags <= (pop && !flush_i) ? head.status : 5'h00;
        end else if (pop && !flush_i) begin
            fflags <= fflags | head.status;
        end
    end

endmodule
